// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the framebuffer pixel side.
// Advances one pixel per enabled clock and registers hpos/vpos together with
// every decode (display_on, hsync, vsync, frame_start) computed from the same
// next position, so position and decode never skew against each other.
// Optional feature macro VGA_FRAME_CNT_EN adds a frame counter output.
module vga_timing_gen #(
    parameter int RESOLUTION_H    = 1280,
    parameter int RESOLUTION_V    = 960,
    parameter int H_FRONT         = 80,
    parameter int H_SYNC          = 136,
    parameter int H_BACK          = 216,
    parameter int V_BOTTOM        = 1,
    parameter int V_SYNC          = 3,
    parameter int V_TOP           = 30,
    parameter bit H_SYNC_POL      = 1'b1,
    parameter bit V_SYNC_POL      = 1'b1,
    parameter int X_WIRE_WIDTH    = $clog2(RESOLUTION_H + H_FRONT + H_SYNC + H_BACK),
    parameter int Y_WIRE_WIDTH    = $clog2(RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP),
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    output logic [X_WIRE_WIDTH-1:0] hpos,
    output logic [Y_WIRE_WIDTH-1:0] vpos,
    output logic                    display_on,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL   = RESOLUTION_H + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP;
    localparam int unsigned H_ACT     = RESOLUTION_H;
    localparam int unsigned V_ACT     = RESOLUTION_V;
    localparam int unsigned HS_START  = RESOLUTION_H + H_FRONT;
    localparam int unsigned HS_END    = RESOLUTION_H + H_FRONT + H_SYNC;
    localparam int unsigned VS_START  = RESOLUTION_V + V_BOTTOM;
    localparam int unsigned VS_END    = RESOLUTION_V + V_BOTTOM + V_SYNC;

    // Reset parks on the last back-porch pixel so the first enabled edge hits (0,0).
    localparam logic [X_WIRE_WIDTH-1:0] H_LAST = X_WIRE_WIDTH'(H_TOTAL - 1);
    localparam logic [Y_WIRE_WIDTH-1:0] V_LAST = Y_WIRE_WIDTH'(V_TOTAL - 1);

    logic [X_WIRE_WIDTH-1:0] hpos_q, hpos_d;
    logic [Y_WIRE_WIDTH-1:0] vpos_q, vpos_d;
    logic                    display_on_q, display_on_d;
    logic                    hsync_q, hsync_d;
    logic                    vsync_q, vsync_d;
    logic                    frame_start_q, frame_start_d;
    logic [31:0]             hx, vy;

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
`endif

    // Next position and its decode; only committed on enabled edges.
    always_comb begin
        hpos_d = hpos_q + 1'b1;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
        end

        // Full-width unsigned compares so the derived constants never truncate.
        hx = 32'(hpos_d);
        vy = 32'(vpos_d);

        display_on_d  = (hx < H_ACT) && (vy < V_ACT);
        hsync_d       = ((hx >= HS_START) && (hx < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d       = ((vy >= VS_START) && (vy < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        frame_start_d = (hpos_d == '0) && (vpos_d == '0);
`ifdef VGA_FRAME_CNT_EN
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
`endif
    end

    // Position and decode registers; en low freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpos_q        <= H_LAST;
            vpos_q        <= V_LAST;
            display_on_q  <= 1'b0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            frame_start_q <= 1'b0;
        end else if (en) begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            display_on_q  <= display_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter starts all-ones so the first frame after reset reads 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '1;
        end else if (en) begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign display_on  = display_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule
